gradient_stream_fifo: RTL and testbench

- Parametrised first-word-fall-through AXI-Stream FIFO for the gradient datapath.
- Successor to the fixed 33-bit stream FIFO wrapper. Adds:
  - configurable data width and depth
  - upstream backpressure (s_axis_tready)
  - occupancy count and programmable almost-full flag
  - synchronous flush
  - sticky overflow/underflow error flags
- Sits between the gradient compute engine and the TCP/IP stack TX stream. The engine throttles on prog_full before the FIFO fills.

---
 rtl/gradient_stream_pkg.sv | 20 ++
 rtl/gradient_fifo_ram.sv | 32 +++
 rtl/gradient_stream_fifo.sv | 107 ++++++++++
 tb/tb_gradient_stream_fifo.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gradient_stream_pkg.sv
// rtl/gradient_stream_pkg.sv - shared defaults and sizing helper for the gradient stream FIFO
package gradient_stream_pkg;

    localparam int GRAD_DATA_W         = 33;  // 32-bit data plus 1 last/flag bit
    localparam int GRAD_FIFO_ADDR_BITS = 5;   // 32-entry default depth

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gradient_fifo_ram.sv
// rtl/gradient_fifo_ram.sv - simple dual-port storage, synchronous write, asynchronous read
//   clk            write clock
//   we/waddr/wdata write port
//   raddr/rdata    combinational read port (distributed-RAM style)
module gradient_fifo_ram
    import gradient_stream_pkg::*;
#(
    parameter int DATA_W    = GRAD_DATA_W,
    parameter int ADDR_BITS = GRAD_FIFO_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [DATA_W-1:0]    rdata
);

    localparam int DEPTH = 1 << ADDR_BITS;

    // No reset on the array so it maps onto LUT RAM.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/gradient_stream_fifo.sv
// rtl/gradient_stream_fifo.sv - first-word-fall-through stream FIFO with occupancy, prog_full and sticky error flags
//   clk, rst               single clock, synchronous active-high reset
//   flush                  synchronous discard of all contents
//   s_axis_tdata/tvalid/tready  write stream
//   m_axis_tdata/tvalid/tready  read stream (head presented without a read request)
//   count                  occupancy 0..DEPTH
//   prog_full              count >= PROG_FULL_THRESH, registered
//   overflow, underflow    sticky, cleared only by rst
module gradient_stream_fifo
    import gradient_stream_pkg::*;
#(
    parameter int DATA_W           = GRAD_DATA_W,
    parameter int ADDR_BITS        = GRAD_FIFO_ADDR_BITS,
    parameter int PROG_FULL_THRESH = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [DATA_W-1:0]    s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [DATA_W-1:0]    m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [ADDR_BITS:0]   count,
    output logic                 prog_full,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int CNT_W = clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0]     FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]     THRESH   = CNT_W'(PROG_FULL_THRESH);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);

    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [CNT_W-1:0]     count_next;
    logic                 push;
    logic                 pop;

    // Handshakes depend only on registered count (and rst), never on the
    // partner's valid/ready, so no combinational loop through the FIFO.
    assign s_axis_tready = (count != FULL_CNT) & ~rst;
    assign m_axis_tvalid = (count != '0);
    assign push          = s_axis_tvalid & s_axis_tready;
    assign pop           = m_axis_tvalid & m_axis_tready;

    gradient_fifo_ram #(
        .DATA_W    (DATA_W),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (push & ~flush),
        .waddr (wr_ptr),
        .wdata (s_axis_tdata),
        .raddr (rd_ptr),
        .rdata (m_axis_tdata)
    );

    // Flush drops any handshake in the same cycle.
    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (push & ~pop) begin
            count_next = count + CNT_ONE;
        end else if (pop & ~push) begin
            count_next = count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            prog_full <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
            end
            count     <= count_next;
            // Compare against the next count so the flag moves with count.
            prog_full <= (count_next >= THRESH);
            if (s_axis_tvalid & ~s_axis_tready) begin
                overflow <= 1'b1;
            end
            if (m_axis_tready & ~m_axis_tvalid) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gradient_stream_fifo.sv
// tb/tb_gradient_stream_fifo.sv - directed self-checking bench for gradient_stream_fifo
module tb_gradient_stream_fifo;

    logic        clk;
    logic        rst;
    logic        flush;

    logic [32:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [32:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [5:0]  cnt;
    logic        pfull;
    logic        ovf;
    logic        unf;

    logic [32:0] sm_s_tdata;
    logic        sm_s_tvalid;
    logic        sm_s_tready;
    logic [32:0] sm_m_tdata;
    logic        sm_m_tvalid;
    logic        sm_m_tready;
    logic [1:0]  sm_cnt;
    logic        sm_pfull;
    logic        sm_ovf;
    logic        sm_unf;

    int tests_run;
    int tests_failed;

    gradient_stream_fifo dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .count         (cnt),
        .prog_full     (pfull),
        .overflow      (ovf),
        .underflow     (unf)
    );

    gradient_stream_fifo #(
        .DATA_W           (33),
        .ADDR_BITS        (1),
        .PROG_FULL_THRESH (2)
    ) dut_small (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .s_axis_tdata  (sm_s_tdata),
        .s_axis_tvalid (sm_s_tvalid),
        .s_axis_tready (sm_s_tready),
        .m_axis_tdata  (sm_m_tdata),
        .m_axis_tvalid (sm_m_tvalid),
        .m_axis_tready (sm_m_tready),
        .count         (sm_cnt),
        .prog_full     (sm_pfull),
        .overflow      (sm_ovf),
        .underflow     (sm_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        flush        = 1'b0;
        s_tdata      = '0;
        s_tvalid     = 1'b0;
        m_tready     = 1'b0;
        sm_s_tdata   = '0;
        sm_s_tvalid  = 1'b0;
        sm_m_tready  = 1'b0;

        // 1. reset state
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_count",     64'(cnt),      64'd0);
        check("rst_tvalid",    64'(m_tvalid), 64'd0);
        check("rst_tready",    64'(s_tready), 64'd1);
        check("rst_prog_full", 64'(pfull),    64'd0);
        check("rst_overflow",  64'(ovf),      64'd0);
        check("rst_underflow", 64'(unf),      64'd0);
        check("rst_sm_count",  64'(sm_cnt),   64'd0);
        check("rst_sm_tready", 64'(sm_s_tready), 64'd1);

        // 2. fill to full, prog_full at 24, overflow on 33rd beat
        for (int i = 1; i <= 32; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 33'(i);
            step();
            if (i == 23) check("pf_before_24", 64'(pfull), 64'd0);
            if (i == 24) check("pf_at_24",     64'(pfull), 64'd1);
            if (i == 31) check("tready_at_31", 64'(s_tready), 64'd1);
        end
        check("full_count",  64'(cnt),      64'd32);
        check("full_tready", 64'(s_tready), 64'd0);
        check("full_ovf0",   64'(ovf),      64'd0);
        s_tdata = 33'h21;
        step();
        s_tvalid = 1'b0;
        check("ovf_set",     64'(ovf), 64'd1);
        check("ovf_count",   64'(cnt), 64'd32);
        m_tready = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            check("drain_valid", 64'(m_tvalid), 64'd1);
            check("drain_data",  64'(m_tdata),  64'(i));
            step();
        end
        m_tready = 1'b0;
        check("drain_count", 64'(cnt),      64'd0);
        check("drain_empty", 64'(m_tvalid), 64'd0);
        check("drain_pf",    64'(pfull),    64'd0);
        check("drain_unf",   64'(unf),      64'd0);

        // 3. steady-state streaming at count 10, pointers wrap many times
        for (int i = 0; i < 10; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 33'(100 + i);
            step();
        end
        check("stream_fill", 64'(cnt), 64'd10);
        m_tready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            s_tdata = 33'(110 + k);
            check("stream_valid", 64'(m_tvalid), 64'd1);
            check("stream_data",  64'(m_tdata),  64'(100 + k));
            step();
            check("stream_count", 64'(cnt), 64'd10);
        end
        s_tvalid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("stream_tail", 64'(m_tdata), 64'(200 + k));
            step();
        end
        m_tready = 1'b0;
        check("stream_empty", 64'(m_tvalid), 64'd0);

        // 4. single beat latency, no bypass
        s_tvalid = 1'b1;
        s_tdata  = 33'h1_DEADBEEF;
        #1;
        check("lat_no_bypass", 64'(m_tvalid), 64'd0);
        step();
        s_tvalid = 1'b0;
        check("lat_valid", 64'(m_tvalid), 64'd1);
        check("lat_data",  64'(m_tdata),  64'h1_DEADBEEF);
        m_tready = 1'b1;
        step();
        m_tready = 1'b0;
        check("lat_pop_valid", 64'(m_tvalid), 64'd0);
        check("lat_pop_count", 64'(cnt),      64'd0);

        // 5. flush with push and pop in the same cycle
        for (int i = 0; i < 20; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 33'(300 + i);
            step();
        end
        check("flush_pre_count", 64'(cnt), 64'd20);
        flush    = 1'b1;
        s_tdata  = 33'h999;
        m_tready = 1'b1;
        step();
        flush    = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        check("flush_count",  64'(cnt),      64'd0);
        check("flush_tvalid", 64'(m_tvalid), 64'd0);
        check("flush_pf",     64'(pfull),    64'd0);
        check("flush_tready", 64'(s_tready), 64'd1);
        check("flush_ovf",    64'(ovf),      64'd1);
        s_tvalid = 1'b1;
        s_tdata  = 33'h1234;
        step();
        s_tvalid = 1'b0;
        check("post_flush_valid", 64'(m_tvalid), 64'd1);
        check("post_flush_data",  64'(m_tdata),  64'h1234);
        check("post_flush_count", 64'(cnt),      64'd1);
        m_tready = 1'b1;
        step();
        check("post_flush_empty", 64'(m_tvalid), 64'd0);

        // underflow: consumer ready on an empty FIFO
        step();
        m_tready = 1'b0;
        check("unf_set", 64'(unf), 64'd1);

        // 6. reset mid-stream at count 17 with overflow set
        for (int i = 0; i < 17; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 33'(500 + i);
            step();
        end
        s_tvalid = 1'b0;
        check("mid_count", 64'(cnt), 64'd17);
        check("mid_ovf",   64'(ovf), 64'd1);
        rst      = 1'b1;
        s_tvalid = 1'b1;
        m_tready = 1'b1;
        step();
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        check("mid_rst_count",  64'(cnt),      64'd0);
        check("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
        check("mid_rst_pf",     64'(pfull),    64'd0);
        check("mid_rst_ovf",    64'(ovf),      64'd0);
        check("mid_rst_unf",    64'(unf),      64'd0);
        check("mid_rst_held",   64'(s_tready), 64'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_tready", 64'(s_tready), 64'd1);

        // 6b. depth-2 instance
        sm_s_tvalid = 1'b1;
        sm_s_tdata  = 33'h1_00000001;
        step();
        check("sm_c1",  64'(sm_cnt),      64'd1);
        check("sm_pf1", 64'(sm_pfull),    64'd0);
        check("sm_rd1", 64'(sm_s_tready), 64'd1);
        sm_s_tdata = 33'h0_00000002;
        step();
        check("sm_c2",  64'(sm_cnt),      64'd2);
        check("sm_pf2", 64'(sm_pfull),    64'd1);
        check("sm_rd2", 64'(sm_s_tready), 64'd0);
        sm_s_tdata = 33'h3;
        step();
        sm_s_tvalid = 1'b0;
        check("sm_ovf",   64'(sm_ovf), 64'd1);
        check("sm_c_ovf", 64'(sm_cnt), 64'd2);
        sm_m_tready = 1'b1;
        check("sm_head1", 64'(sm_m_tdata), 64'h1_00000001);
        step();
        check("sm_head2", 64'(sm_m_tdata), 64'h0_00000002);
        check("sm_pf_dn", 64'(sm_pfull),   64'd0);
        // simultaneous push and pop at count 1 across the pointer wrap
        sm_s_tvalid = 1'b1;
        sm_s_tdata  = 33'h0_0000ABCD;
        step();
        sm_s_tvalid = 1'b0;
        sm_m_tready = 1'b0;
        check("sm_pp_count", 64'(sm_cnt),     64'd1);
        check("sm_pp_data",  64'(sm_m_tdata), 64'h0_0000ABCD);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("sm_rst_count",  64'(sm_cnt),      64'd0);
        check("sm_rst_tvalid", 64'(sm_m_tvalid), 64'd0);
        check("sm_rst_ovf",    64'(sm_ovf),      64'd0);
        check("sm_rst_tready", 64'(sm_s_tready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
